axi_lite_param_loader: RTL and testbench
========================================

Name: axi_lite_param_loader

Overview:
- AXI4-Lite slave that writes the flat parameter bus consumed by the generated control-system interconnect (cell_control_system_interconnect).
- Software writes 32-bit words into a shadow register. A write to the COMMIT register copies the shadow to `axi_params` atomically and pulses `param_en` for one cycle.
- Sits between the PS/AXI fabric and the `axi_params`/`param_en` inputs of the interconnect.

Parameters:
- PARAM_W, 1344, width of `axi_params` in bits.
- ADDR_W, 8, AXI byte-address width.
- NWORDS, (PARAM_W+31)/32 = 42, number of shadow words; derived, do not override.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous active-low reset
- s_awaddr  in  ADDR_W  write address
- s_awvalid  in  1  write address valid
- s_awready  out  1  write address ready
- s_wdata  in  32  write data
- s_wstrb  in  4  byte strobes
- s_wvalid  in  1  write data valid
- s_wready  out  1  write data ready
- s_bresp  out  2  write response (00 OKAY, 10 SLVERR)
- s_bvalid  out  1  write response valid
- s_bready  in  1  write response ready
- s_araddr  in  ADDR_W  read address
- s_arvalid  in  1  read address valid
- s_arready  out  1  read address ready
- s_rdata  out  32  read data
- s_rresp  out  2  read response
- s_rvalid  out  1  read valid
- s_rready  in  1  read ready
- axi_params  out  PARAM_W  committed parameter bus
- param_en  out  1  one-cycle commit strobe

Behaviour:
- Reset: `rst`=0 asynchronously clears all state.
  - Shadow words, `axi_params`, `param_en`, `s_bvalid`, `s_rvalid`, `s_rdata`, `s_bresp` and `s_rresp` all go to 0.
  - `s_awready`, `s_wready` and `s_arready` go to 1 once out of reset.
  - Reset mid-transaction abandons the transaction with no response and no commit.
- Address map (byte address; bits [1:0] ignored):
  - 4*i for i < NWORDS: shadow word i, which maps to `axi_params[32i+31:32i]`. Bits at or above PARAM_W are not stored and read 0.
  - 0xFC: COMMIT. A write with wstrb[0]=1 and wdata[0]=1 commits. Reads return 0 with OKAY.
  - Any other address: SLVERR. Writes have no effect; reads return 0.
- Write FSM, states W_IDLE, W_EXEC, W_RESP:
  - W_IDLE: AW and W are captured independently. `s_awready` drops after AW is captured, and `s_wready` drops after W is captured. Both may be captured in the same cycle. Once both are held, go to W_EXEC.
  - W_EXEC (one cycle): apply the byte-masked shadow write, or perform the commit. Compute bresp. Go to W_RESP.
  - W_RESP: `s_bvalid`=1 and is held until `s_bready`=1. Return to W_IDLE in the cycle after the handshake, with both readies high again.
  - Minimum write latency: AW+W handshake at edge N, shadow updated at N+1, `s_bvalid` high from N+1.
- Commit:
  - At the W_EXEC edge, `axi_params` <= shadow (including any bytes written earlier) and `param_en`=1 for exactly that one following cycle.
  - `axi_params` is otherwise stable; shadow writes never disturb it.
  - A commit write with wdata[0]=0 is OKAY with no effect.
- Read FSM, states R_IDLE, R_RESP:
  - R_IDLE: `s_arready`=1. On handshake, register `s_rdata`/`s_rresp` from the current shadow and go to R_RESP.
  - R_RESP: `s_rvalid`=1 and data is held until `s_rready`=1, then return to R_IDLE.
  - Read latency: one cycle from AR handshake to `s_rvalid`.
- Read and write channels are independent. A read accepted in the same cycle as a W_EXEC to the same word returns the pre-write value.
- Back-to-back commits: each completes its own `param_en` pulse. The minimum spacing is set by the B handshake (3 cycles with `s_bready` tied high).

Optional Feature:
- Macro PARAM_STATUS_EN.
- Defined: address 0xF8 is STATUS, read-only.
  - rdata[15:0] = commit counter. It increments on each commit and wraps at 0xFFFF to 0.
  - rdata[16] = 1 while the write FSM is not in W_IDLE.
  - Writes to STATUS return SLVERR and have no effect.
  - The counter resets to 0.
- Undefined: 0xF8 is an unmapped address and returns SLVERR with rdata 0.

Test Plan:
- Write 0xDEADBEEF to 0x00, strobe 0xF, then read 0x00. Require bresp=00, rdata=0xDEADBEEF, `axi_params` still 0, `param_en` never high.
- Write 0x00000010 to 0x00, then write 1 to 0xFC. Require `param_en` high for exactly one cycle, `axi_params[31:0]`=0x10, all other bits 0.
- Write 0xFFFFFFFF to 0x00 with wstrb=0x2. Require a shadow readback of 0x0000FF00, with the other bytes unchanged.
- Present W two cycles before AW, with `s_bready` low for 5 cycles. Require a single write, `s_bvalid` held for 5 cycles, and no second response.
- Write to and read from 0xB0. Require SLVERR on both, rdata=0, and no change to the shadow.
- With PARAM_STATUS_EN: issue 3 commits, then read 0xF8. Require rdata=0x00000003. Without it: reading 0xF8 returns SLVERR.

Source files
------------

// File: rtl/axi_lite_param_loader.sv
// AXI4-Lite slave that stages 32-bit words in a shadow array and commits them atomically to axi_params.
// Optional feature macro PARAM_STATUS_EN adds a read-only STATUS register at 0xF8.
module axi_lite_param_loader #(
  parameter  int PARAM_W = 1344,
  parameter  int ADDR_W  = 8,
  localparam int NWORDS  = (PARAM_W + 31) / 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [ADDR_W-1:0]  s_awaddr,
  input  logic               s_awvalid,
  output logic               s_awready,
  input  logic [31:0]        s_wdata,
  input  logic [3:0]         s_wstrb,
  input  logic               s_wvalid,
  output logic               s_wready,
  output logic [1:0]         s_bresp,
  output logic               s_bvalid,
  input  logic               s_bready,
  input  logic [ADDR_W-1:0]  s_araddr,
  input  logic               s_arvalid,
  output logic               s_arready,
  output logic [31:0]        s_rdata,
  output logic [1:0]         s_rresp,
  output logic               s_rvalid,
  input  logic               s_rready,
  output logic [PARAM_W-1:0] axi_params,
  output logic               param_en
);

  localparam int             IW         = ADDR_W - 2;
  localparam logic [IW-1:0]  COMMIT_IDX = IW'(8'hFC >> 2);
  localparam logic [IW-1:0]  STATUS_IDX = IW'(8'hF8 >> 2);
  localparam logic [1:0]     RESP_OKAY  = 2'b00;
  localparam logic [1:0]     RESP_SLV   = 2'b10;

  typedef enum logic [1:0] {W_IDLE, W_EXEC, W_RESP} w_state_t;
  typedef enum logic       {R_IDLE, R_RESP}         r_state_t;

  w_state_t w_state, w_next;
  r_state_t r_state, r_next;

  logic              aw_held, w_held;
  logic [IW-1:0]     aw_idx;
  logic [31:0]       w_data;
  logic [3:0]        w_strb;
  logic              aw_fire, w_fire, ar_fire;
  logic [31:0]       shadow [NWORDS];
  logic [NWORDS*32-1:0] shadow_flat;
  logic              wr_is_shadow, wr_is_commit, commit_go;
  logic [IW-1:0]     ar_idx;
  logic [31:0]       rd_word;
  logic              rd_ok;
  logic              unused_ok;

  // Bits of word idx that land inside PARAM_W; bits beyond are never stored.
  function automatic logic [31:0] valid_mask(input logic [IW-1:0] idx);
    for (int k = 0; k < 32; k++) valid_mask[k] = (32 * int'(idx) + k) < PARAM_W;
  endfunction

  function automatic logic [31:0] strb_mask(input logic [3:0] s);
    strb_mask = {{8{s[3]}}, {8{s[2]}}, {8{s[1]}}, {8{s[0]}}};
  endfunction

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      w_state <= W_IDLE;
      r_state <= R_IDLE;
    end else begin
      w_state <= w_next;
      r_state <= r_next;
    end
  end

  always_comb begin
    w_next    = w_state;
    s_awready = 1'b0;
    s_wready  = 1'b0;
    s_bvalid  = 1'b0;
    aw_fire   = 1'b0;
    w_fire    = 1'b0;
    case (w_state)
      W_IDLE: begin
        s_awready = !aw_held;
        s_wready  = !w_held;
        aw_fire   = s_awvalid && !aw_held;
        w_fire    = s_wvalid && !w_held;
        if ((aw_held || aw_fire) && (w_held || w_fire)) w_next = W_EXEC;
      end
      W_EXEC: w_next = W_RESP;
      W_RESP: begin
        s_bvalid = 1'b1;
        if (s_bready) w_next = W_IDLE;
      end
      default: w_next = W_IDLE;
    endcase
  end

  always_comb begin
    r_next    = r_state;
    s_arready = 1'b0;
    s_rvalid  = 1'b0;
    ar_fire   = 1'b0;
    case (r_state)
      R_IDLE: begin
        s_arready = 1'b1;
        ar_fire   = s_arvalid;
        if (s_arvalid) r_next = R_RESP;
      end
      R_RESP: begin
        s_rvalid = 1'b1;
        if (s_rready) r_next = R_IDLE;
      end
      default: r_next = R_IDLE;
    endcase
  end

  // AW and W are latched independently; both holds clear as the write executes.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      aw_held <= 1'b0;
      w_held  <= 1'b0;
      aw_idx  <= '0;
      w_data  <= '0;
      w_strb  <= '0;
    end else if (w_state == W_EXEC) begin
      aw_held <= 1'b0;
      w_held  <= 1'b0;
    end else begin
      if (aw_fire) begin
        aw_held <= 1'b1;
        aw_idx  <= s_awaddr[ADDR_W-1:2];
      end
      if (w_fire) begin
        w_held <= 1'b1;
        w_data <= s_wdata;
        w_strb <= s_wstrb;
      end
    end
  end

  always_comb begin
    for (int i = 0; i < NWORDS; i++) shadow_flat[32*i +: 32] = shadow[i];
    wr_is_shadow = int'(aw_idx) < NWORDS;
    wr_is_commit = aw_idx == COMMIT_IDX;
    commit_go    = (w_state == W_EXEC) && wr_is_commit && w_strb[0] && w_data[0];
  end

`ifdef PARAM_STATUS_EN
  logic [15:0] commit_cnt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)           commit_cnt <= '0;
    else if (commit_go) commit_cnt <= commit_cnt + 16'd1;
  end
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < NWORDS; i++) shadow[i] <= '0;
      axi_params <= '0;
      param_en   <= 1'b0;
      s_bresp    <= RESP_OKAY;
    end else begin
      param_en <= 1'b0;
      if (w_state == W_EXEC) begin
        s_bresp <= (wr_is_shadow || wr_is_commit) ? RESP_OKAY : RESP_SLV;
        for (int i = 0; i < NWORDS; i++) begin
          if (wr_is_shadow && aw_idx == IW'(i))
            shadow[i] <= (shadow[i] & ~strb_mask(w_strb))
                       | (w_data & strb_mask(w_strb) & valid_mask(aw_idx));
        end
      end
      // Commit samples the shadow as it stood before this edge.
      if (commit_go) begin
        axi_params <= shadow_flat[PARAM_W-1:0];
        param_en   <= 1'b1;
      end
    end
  end

  always_comb begin
    ar_idx  = s_araddr[ADDR_W-1:2];
    rd_word = '0;
    rd_ok   = 1'b0;
    if (int'(ar_idx) < NWORDS) begin
      rd_ok = 1'b1;
      for (int i = 0; i < NWORDS; i++)
        if (ar_idx == IW'(i)) rd_word = shadow[i];
    end else if (ar_idx == COMMIT_IDX) begin
      rd_ok = 1'b1;
`ifdef PARAM_STATUS_EN
    end else if (ar_idx == STATUS_IDX) begin
      rd_ok   = 1'b1;
      rd_word = {15'd0, w_state != W_IDLE, commit_cnt};
`endif
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s_rdata <= '0;
      s_rresp <= RESP_OKAY;
    end else if (ar_fire) begin
      s_rdata <= rd_word;
      s_rresp <= rd_ok ? RESP_OKAY : RESP_SLV;
    end
  end

  assign unused_ok = ^{s_awaddr[1:0], s_araddr[1:0], shadow_flat, STATUS_IDX};

endmodule

// File: tb/tb_axi_lite_param_loader.sv
// Directed self-checking bench for axi_lite_param_loader (default build or PARAM_STATUS_EN).
module tb_axi_lite_param_loader;

  localparam int PARAM_W = 1344;
  localparam int ADDR_W  = 8;

  logic               clk = 1'b0;
  logic               rst;
  logic [ADDR_W-1:0]  s_awaddr;
  logic               s_awvalid;
  logic               s_awready;
  logic [31:0]        s_wdata;
  logic [3:0]         s_wstrb;
  logic               s_wvalid;
  logic               s_wready;
  logic [1:0]         s_bresp;
  logic               s_bvalid;
  logic               s_bready;
  logic [ADDR_W-1:0]  s_araddr;
  logic               s_arvalid;
  logic               s_arready;
  logic [31:0]        s_rdata;
  logic [1:0]         s_rresp;
  logic               s_rvalid;
  logic               s_rready;
  logic [PARAM_W-1:0] axi_params;
  logic               param_en;

  int checks   = 0;
  int failures = 0;
  int pe_cycles = 0;
  logic pe_double = 1'b0;
  logic pe_prev   = 1'b0;

  axi_lite_param_loader #(.PARAM_W(PARAM_W), .ADDR_W(ADDR_W)) dut (
    .clk(clk), .rst(rst),
    .s_awaddr(s_awaddr), .s_awvalid(s_awvalid), .s_awready(s_awready),
    .s_wdata(s_wdata), .s_wstrb(s_wstrb), .s_wvalid(s_wvalid), .s_wready(s_wready),
    .s_bresp(s_bresp), .s_bvalid(s_bvalid), .s_bready(s_bready),
    .s_araddr(s_araddr), .s_arvalid(s_arvalid), .s_arready(s_arready),
    .s_rdata(s_rdata), .s_rresp(s_rresp), .s_rvalid(s_rvalid), .s_rready(s_rready),
    .axi_params(axi_params), .param_en(param_en)
  );

  always #5 clk = ~clk;

  // Counts param_en cycles and flags any pulse longer than one cycle.
  always @(negedge clk) begin
    if (rst) begin
      if (param_en) pe_cycles++;
      if (param_en && pe_prev) pe_double = 1'b1;
      pe_prev = param_en;
    end else begin
      pe_prev = 1'b0;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic axi_write(input logic [7:0] addr, input logic [31:0] data,
                           input logic [3:0] strb, output logic [1:0] resp);
    logic aw_p, w_p, af, wf, done;
    int n;
    @(negedge clk);
    s_awaddr = addr; s_wdata = data; s_wstrb = strb;
    s_awvalid = 1'b1; s_wvalid = 1'b1;
    aw_p = 1'b1; w_p = 1'b1; n = 0;
    while ((aw_p || w_p) && n < 20) begin
      af = s_awvalid && s_awready;
      wf = s_wvalid && s_wready;
      @(posedge clk); #1;
      if (af) begin s_awvalid = 1'b0; aw_p = 1'b0; end
      if (wf) begin s_wvalid = 1'b0; w_p = 1'b0; end
      n++;
    end
    s_awvalid = 1'b0; s_wvalid = 1'b0;
    chk("wr_accept", 32'(!(aw_p || w_p)), 32'd1);
    s_bready = 1'b1; done = 1'b0; n = 0; resp = 2'bxx;
    while (!done && n < 20) begin
      if (s_bvalid) begin resp = s_bresp; done = 1'b1; end
      @(posedge clk); #1;
      n++;
    end
    s_bready = 1'b0;
    chk("wr_bresp_seen", 32'(done), 32'd1);
  endtask

  task automatic axi_read(input logic [7:0] addr, output logic [31:0] data,
                          output logic [1:0] resp);
    logic pend, fire, done;
    int n;
    @(negedge clk);
    s_araddr = addr; s_arvalid = 1'b1;
    pend = 1'b1; n = 0;
    while (pend && n < 20) begin
      fire = s_arvalid && s_arready;
      @(posedge clk); #1;
      if (fire) begin s_arvalid = 1'b0; pend = 1'b0; end
      n++;
    end
    s_arvalid = 1'b0;
    chk("rd_accept", 32'(!pend), 32'd1);
    chk("rd_latency", 32'(s_rvalid), 32'd1);
    s_rready = 1'b1; done = 1'b0; n = 0; data = 'x; resp = 2'bxx;
    while (!done && n < 20) begin
      if (s_rvalid) begin data = s_rdata; resp = s_rresp; done = 1'b1; end
      @(posedge clk); #1;
      n++;
    end
    s_rready = 1'b0;
    chk("rd_resp_seen", 32'(done), 32'd1);
  endtask

  initial begin
    logic [1:0]  resp;
    logic [31:0] data;
    int bv_cnt;
    int pe_before;

    rst = 1'b1;
    s_awaddr = '0; s_awvalid = 1'b0; s_wdata = '0; s_wstrb = '0; s_wvalid = 1'b0;
    s_bready = 1'b0; s_araddr = '0; s_arvalid = 1'b0; s_rready = 1'b0;
    #2 rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_bvalid", 32'(s_bvalid), 32'd0);
    chk("rst_rvalid", 32'(s_rvalid), 32'd0);
    chk("rst_param_en", 32'(param_en), 32'd0);
    chk("rst_params", 32'(|axi_params), 32'd0);
    chk("rst_rdata", s_rdata, 32'd0);
    chk("rst_bresp", 32'(s_bresp), 32'd0);
    chk("rst_rresp", 32'(s_rresp), 32'd0);
    @(negedge clk); rst = 1'b1;
    @(posedge clk); #1;
    chk("rst_awready", 32'(s_awready), 32'd1);
    chk("rst_wready", 32'(s_wready), 32'd1);
    chk("rst_arready", 32'(s_arready), 32'd1);

    // Plain shadow write does not touch the committed bus.
    axi_write(8'h00, 32'hDEADBEEF, 4'hF, resp);
    chk("t1_bresp", 32'(resp), 32'd0);
    axi_read(8'h00, data, resp);
    chk("t1_rdata", data, 32'hDEADBEEF);
    chk("t1_rresp", 32'(resp), 32'd0);
    chk("t1_params_zero", 32'(|axi_params), 32'd0);
    chk("t1_no_param_en", pe_cycles, 32'd0);

    // Commit.
    axi_write(8'h00, 32'h00000010, 4'hF, resp);
    axi_write(8'hFC, 32'h00000001, 4'hF, resp);
    chk("t2_commit_bresp", 32'(resp), 32'd0);
    chk("t2_pe_cycles", pe_cycles, 32'd1);
    chk("t2_pe_single", 32'(pe_double), 32'd0);
    chk("t2_params_lo", axi_params[31:0], 32'h00000010);
    chk("t2_params_hi_zero", 32'(|axi_params[PARAM_W-1:32]), 32'd0);
    axi_read(8'hFC, data, resp);
    chk("t2_commit_rdata", data, 32'd0);
    chk("t2_commit_rresp", 32'(resp), 32'd0);
    axi_write(8'hFC, 32'h00000000, 4'hF, resp);
    repeat (2) @(posedge clk);
    chk("t2_nocommit_bresp", 32'(resp), 32'd0);
    chk("t2_nocommit_pe", pe_cycles, 32'd1);

    // Byte strobes.
    axi_write(8'h00, 32'h00000000, 4'hF, resp);
    axi_write(8'h00, 32'hFFFFFFFF, 4'h2, resp);
    axi_read(8'h00, data, resp);
    chk("t3_strb2", data, 32'h0000FF00);
    axi_write(8'h04, 32'h11223344, 4'hF, resp);
    axi_write(8'h04, 32'hAABBCCDD, 4'h5, resp);
    axi_read(8'h04, data, resp);
    chk("t3_strb5", data, 32'h11BB33DD);
    chk("t3_params_stable", axi_params[31:0], 32'h00000010);

    // W two cycles ahead of AW, B held off for 5 cycles.
    @(negedge clk);
    s_wdata = 32'hCAFEF00D; s_wstrb = 4'hF; s_wvalid = 1'b1; s_bready = 1'b0;
    @(posedge clk); #1;
    s_wvalid = 1'b0;
    chk("t4_wready_drop", 32'(s_wready), 32'd0);
    chk("t4_awready_hold", 32'(s_awready), 32'd1);
    @(posedge clk); #1;
    s_awaddr = 8'h08; s_awvalid = 1'b1;
    @(posedge clk); #1;
    s_awvalid = 1'b0;
    chk("t4_exec_no_bvalid", 32'(s_bvalid), 32'd0);
    @(posedge clk); #1;
    bv_cnt = 0;
    for (int k = 0; k < 5; k++) begin
      if (s_bvalid) bv_cnt++;
      @(posedge clk); #1;
    end
    chk("t4_bvalid_held", bv_cnt, 32'd5);
    chk("t4_bresp", 32'(s_bresp), 32'd0);
    s_bready = 1'b1;
    @(posedge clk); #1;
    s_bready = 1'b0;
    chk("t4_bvalid_clear", 32'(s_bvalid), 32'd0);
    chk("t4_readies_back", 32'({s_awready, s_wready}), 32'd3);
    bv_cnt = 0;
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); #1;
      if (s_bvalid) bv_cnt++;
    end
    chk("t4_no_second_resp", bv_cnt, 32'd0);
    axi_read(8'h08, data, resp);
    chk("t4_rdata", data, 32'hCAFEF00D);

    // Unmapped addresses and the last shadow word.
    axi_write(8'hB0, 32'h12345678, 4'hF, resp);
    chk("t5_wr_slverr", 32'(resp), 32'd2);
    axi_read(8'hB0, data, resp);
    chk("t5_rd_slverr", 32'(resp), 32'd2);
    chk("t5_rd_zero", data, 32'd0);
    axi_read(8'h00, data, resp);
    chk("t5_shadow_intact", data, 32'h0000FF00);
    axi_write(8'hA8, 32'h12345678, 4'hF, resp);
    chk("t5_past_end_slverr", 32'(resp), 32'd2);
    axi_write(8'hA4, 32'h5A5AA5A5, 4'hF, resp);
    chk("t5_last_word_okay", 32'(resp), 32'd0);
    axi_read(8'hA4, data, resp);
    chk("t5_last_word_rd", data, 32'h5A5AA5A5);

    // Three back-to-back commits.
    for (int k = 0; k < 3; k++) axi_write(8'hFC, 32'h00000001, 4'h1, resp);
    repeat (2) @(posedge clk);
    chk("t6_pe_cycles", pe_cycles, 32'd4);
    chk("t6_pe_single", 32'(pe_double), 32'd0);
    chk("t6_params_w0", axi_params[31:0], 32'h0000FF00);
    chk("t6_params_w2", axi_params[95:64], 32'hCAFEF00D);
    chk("t6_params_w41", axi_params[1343:1312], 32'h5A5AA5A5);
    axi_read(8'hF8, data, resp);
`ifdef PARAM_STATUS_EN
    chk("t6_status_rdata", data, 32'h00000004);
    chk("t6_status_rresp", 32'(resp), 32'd0);
`else
    chk("t6_status_rdata", data, 32'd0);
    chk("t6_status_rresp", 32'(resp), 32'd2);
`endif
    axi_write(8'hF8, 32'hFFFFFFFF, 4'hF, resp);
    chk("t6_status_wr_slverr", 32'(resp), 32'd2);

    // Reset during the execute cycle of a commit abandons it.
    axi_write(8'h00, 32'h00000077, 4'hF, resp);
    pe_before = pe_cycles;
    @(negedge clk);
    s_awaddr = 8'hFC; s_wdata = 32'h1; s_wstrb = 4'hF; s_awvalid = 1'b1; s_wvalid = 1'b1;
    @(posedge clk); #1;
    s_awvalid = 1'b0; s_wvalid = 1'b0;
    rst = 1'b0;
    #1;
    chk("t7_rst_param_en", 32'(param_en), 32'd0);
    chk("t7_rst_params", 32'(|axi_params), 32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk); rst = 1'b1;
    repeat (3) @(posedge clk); #1;
    chk("t7_no_bvalid", 32'(s_bvalid), 32'd0);
    chk("t7_no_commit", pe_cycles, pe_before);
    chk("t7_params_zero", 32'(|axi_params), 32'd0);
    axi_read(8'h00, data, resp);
    chk("t7_shadow_cleared", data, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
